// File: rtl/send_feedback_pkg.sv
// send_feedback_pkg: memory map, cost constants and FSM states shared by send_feedback and the cost learner.
package send_feedback_pkg;
  localparam int          WORD_WIDTH   = 16;
  localparam logic [15:0] INF_COST     = 16'hFFFF;
  localparam logic [15:0] NCOUNT_ADDR  = 16'h068A;
  localparam logic [15:0] KSCOUNT_ADDR = 16'h0688;
  localparam logic [15:0] KSINK_BASE   = 16'h0008;
  localparam logic [15:0] NID_BASE     = 16'h0048;
  localparam logic [15:0] CLUS_BASE    = 16'h00C8;
  localparam logic [15:0] BATT_BASE    = 16'h0148;
  localparam logic [15:0] QVAL_BASE    = 16'h01C8;
  localparam logic [15:0] SINK_BASE    = 16'h0248;
  localparam logic [15:0] MYID_ADDR    = 16'h0000;
  localparam logic [15:0] MYBATT_ADDR  = 16'h0002;
  localparam logic [15:0] MYCLUS_ADDR  = 16'h0004;
  typedef enum logic [3:0] {
    S_IDLE, S_RD_NCNT, S_SCAN_A, S_SCAN_D, S_RD_NID,
    S_RD_ID, S_RD_BATT, S_RD_CLUS, S_COMPUTE, S_SEND, S_DONE
  } state_e;
endpackage

// File: rtl/send_feedback_sat_add16.sv
// sat_add16: combinational 16-bit unsigned adder that clamps at 16'hFFFF.
module sat_add16 (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] y_o
);
  logic [16:0] sum;
  assign sum = {1'b0, a_i} + {1'b0, b_i};
  assign y_o = sum[16] ? 16'hFFFF : sum[15:0];
endmodule

// File: rtl/send_feedback.sv
// send_feedback: scans the routing table for the min-qValue neighbour and sends one feedback packet.
// Optional BATTERY_COST_EN adds a battery-deficit term to the advertised cost.
module send_feedback
  import send_feedback_pkg::*;
#(
  parameter int          MAX_NEIGHBORS = 64,
  parameter logic [15:0] HOP_COST      = 16'd1,
  parameter int          BATT_SHIFT    = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic [15:0] address,
  input  logic [15:0] data_in,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [15:0] tx_sourceID,
  output logic [15:0] tx_batteryStat,
  output logic [15:0] tx_value,
  output logic [15:0] tx_clusterID,
  output logic [15:0] best_nID,
  output logic        busy,
  output logic        done
);
  state_e      state_q, state_d;
  logic        ph_q, ph_d;
  logic [6:0]  n_q, n_d, cnt_q, cnt_d, ncl;
  logic [15:0] min_q, min_d, best_q, best_d, addr_q, addr_d;
  logic [15:0] id_q, id_d, batt_q, batt_d, clus_q, clus_d, val_q, val_d;
  logic [15:0] hop, cost;
  logic        last;
  sat_add16 u_hop (.a_i(min_q), .b_i(HOP_COST), .y_o(hop));
`ifdef BATTERY_COST_EN
  logic [15:0] deficit;
  assign deficit = (INF_COST - batt_q) >> BATT_SHIFT;
  sat_add16 u_batt (.a_i(hop), .b_i(deficit), .y_o(cost));
`else
  assign cost = hop;
`endif
  assign ncl  = (data_in > 16'(MAX_NEIGHBORS)) ? 7'(MAX_NEIGHBORS) : data_in[6:0];
  assign last = n_q == cnt_q - 7'd1;
  always_comb begin
    state_d = state_q;
    ph_d    = 1'b0;
    n_d     = n_q;
    cnt_d   = cnt_q;
    min_d   = min_q;
    best_d  = best_q;
    id_d    = id_q;
    batt_d  = batt_q;
    clus_d  = clus_q;
    val_d   = val_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_RD_NCNT;
        n_d     = '0;
        min_d   = INF_COST;
        best_d  = INF_COST;
      end
      S_RD_NCNT: begin
        ph_d = ~ph_q;
        if (ph_q) begin
          cnt_d   = ncl;
          state_d = (ncl == '0) ? S_RD_ID : S_SCAN_A;
        end
      end
      S_SCAN_A: state_d = S_SCAN_D;
      S_SCAN_D: begin
        if (data_in < min_q) begin
          min_d   = data_in;
          state_d = S_RD_NID;
        end else begin
          state_d = last ? S_RD_ID : S_SCAN_A;
          n_d     = last ? n_q : n_q + 7'd1;
        end
      end
      S_RD_NID: begin
        ph_d = ~ph_q;
        if (ph_q) begin
          best_d  = data_in;
          state_d = last ? S_RD_ID : S_SCAN_A;
          n_d     = last ? n_q : n_q + 7'd1;
        end
      end
      S_RD_ID: begin
        ph_d = ~ph_q;
        if (ph_q) begin
          id_d    = data_in;
          state_d = S_RD_BATT;
        end
      end
      S_RD_BATT: begin
        ph_d = ~ph_q;
        if (ph_q) begin
          batt_d  = data_in;
          state_d = S_RD_CLUS;
        end
      end
      S_RD_CLUS: begin
        ph_d = ~ph_q;
        if (ph_q) begin
          clus_d  = data_in;
          state_d = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        val_d   = (cnt_q == '0) ? INF_COST : cost;
        state_d = S_SEND;
      end
      S_SEND:  state_d = tx_ready ? S_DONE : S_SEND;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  // Address is registered one cycle ahead so memory sees it in the first cycle of each read.
  always_comb begin
    addr_d = addr_q;
    case (state_d)
      S_RD_NCNT:          addr_d = NCOUNT_ADDR;
      S_SCAN_A, S_SCAN_D: addr_d = QVAL_BASE + {8'd0, n_d, 1'b0};
      S_RD_NID:           addr_d = NID_BASE + {8'd0, n_d, 1'b0};
      S_RD_ID:            addr_d = MYID_ADDR;
      S_RD_BATT:          addr_d = MYBATT_ADDR;
      S_RD_CLUS:          addr_d = MYCLUS_ADDR;
      default:            addr_d = addr_q;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      ph_q    <= 1'b0;
      n_q     <= '0;
      cnt_q   <= '0;
      min_q   <= INF_COST;
      best_q  <= INF_COST;
      addr_q  <= '0;
      id_q    <= '0;
      batt_q  <= '0;
      clus_q  <= '0;
      val_q   <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      min_q   <= min_d;
      best_q  <= best_d;
      addr_q  <= addr_d;
      id_q    <= id_d;
      batt_q  <= batt_d;
      clus_q  <= clus_d;
      val_q   <= val_d;
    end
  end
  assign address        = addr_q;
  assign tx_valid       = state_q == S_SEND;
  assign done           = state_q == S_DONE;
  assign busy           = (state_q != S_IDLE) && (state_q != S_DONE);
  assign tx_sourceID    = id_q;
  assign tx_batteryStat = batt_q;
  assign tx_clusterID   = clus_q;
  assign tx_value       = val_q;
  assign best_nID       = best_q;
endmodule
